// File: rtl/mem_bus_pkg.sv
// Shared types for the two-master memory bus arbiter.
//   arb_state_t : arbiter FSM encoding (IDLE / BUSY)
//   midx_t      : master index
//   mem_req_t   : forwarded request fields (addr / wdata / wstrb)
//   rr_pick     : round-robin choice among requesting masters
package mem_bus_pkg;

  localparam int NUM_MASTERS = 2;
  localparam int MIDX_W      = $clog2(NUM_MASTERS);

  typedef logic [MIDX_W-1:0] midx_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mem_req_t;

  // On a tie the master that did not finish last wins; with no request the
  // current index is kept so grant keeps reporting the last owner.
  function automatic midx_t rr_pick(input logic [NUM_MASTERS-1:0] req,
                                    input midx_t last, input midx_t cur);
    midx_t pick;
    pick = cur;
    if (&req)        pick = ~last;
    else if (req[0]) pick = midx_t'(0);
    else if (req[1]) pick = midx_t'(1);
    return pick;
  endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Bus-timeout watchdog for the arbiter.
//   clk, resetn   : clock, async active-low reset
//   en            : a granted request is in flight (BUSY with valid high)
//   s_ready       : shared bus completion
//   addr          : address of the in-flight request
//   fire          : this cycle is a forced completion (one cycle wide)
//   timeout_addr  : address captured on the last forced completion
module bus_watchdog
  #(parameter int TIMEOUT_CYCLES = 255)
  (
  input  logic        clk,
  input  logic        resetn,
  input  logic        en,
  input  logic        s_ready,
  input  logic [31:0] addr,
  output logic        fire,
  output logic [31:0] timeout_addr
  );

  // Width holds 0..TIMEOUT_CYCLES; kept at least 1 bit so a disabled
  // watchdog still elaborates.
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic [CW-1:0] cnt;

  // s_ready has priority: a late response is a normal completion.
  assign fire = (TIMEOUT_CYCLES > 0) && en && !s_ready && (cnt == LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt          <= '0;
      timeout_addr <= '0;
    end else begin
      if (!en)
        cnt <= '0;
      else if (!s_ready && !fire && cnt != '1)
        cnt <= cnt + CW'(1);
      if (fire)
        timeout_addr <= addr;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master / one-slave arbiter for a picorv32-style native memory bus.
// Round-robin grant, grant held until the transaction completes or the
// master aborts, and a watchdog that force-completes hung transfers.
//   clk, resetn        : clock, async active-low reset
//   m0_* / m1_*        : master ports (valid/addr/wdata/wstrb in, ready/rdata out)
//   s_*                : shared slave bus (valid/addr/wdata/wstrb out, ready/rdata in)
//   timeout_irq        : one-cycle pulse on a forced completion
//   timeout_addr       : address of the last timed-out transfer
//   grant              : current or last granted master
module mem_bus_arbiter
  import mem_bus_pkg::*;
  #(parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] TIMEOUT_RDATA  = 32'h0000_0000)
  (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  input  logic        s_ready,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic [31:0] s_rdata,
  output logic        timeout_irq,
  output logic [31:0] timeout_addr,
  output logic        grant
  );

  arb_state_t state, state_nxt;
  midx_t      grant_q, grant_nxt, last_q, last_nxt;

  logic     [NUM_MASTERS-1:0]       m_valid, m_ready;
  mem_req_t [NUM_MASTERS-1:0]       m_req;
  logic     [NUM_MASTERS-1:0][31:0] m_rdata;
  mem_req_t sel_req;
  logic     sel_valid, busy, wd_fire;

  assign m_valid  = {m1_valid, m0_valid};
  assign m_req[0] = {m0_addr, m0_wdata, m0_wstrb};
  assign m_req[1] = {m1_addr, m1_wdata, m1_wstrb};

  assign sel_req   = m_req[grant_q];
  assign sel_valid = m_valid[grant_q];
  assign busy      = (state == BUSY);

  assign s_addr  = sel_req.addr;
  assign s_wdata = sel_req.wdata;
  assign s_wstrb = sel_req.wstrb;

  bus_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
    .clk          (clk),
    .resetn       (resetn),
    .en           (busy && sel_valid),
    .s_ready      (s_ready),
    .addr         (sel_req.addr),
    .fire         (wd_fire),
    .timeout_addr (timeout_addr)
  );

  always_comb begin
    state_nxt = state;
    grant_nxt = grant_q;
    last_nxt  = last_q;
    s_valid   = 1'b0;
    m_ready   = '0;
    case (state)
      IDLE: begin
        if (|m_valid) begin
          grant_nxt = rr_pick(m_valid, last_q, grant_q);
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (!sel_valid) begin
          // Master withdrew: release the bus without completing.
          state_nxt = IDLE;
        end else begin
          s_valid = !wd_fire;
          if (s_ready || wd_fire) begin
            m_ready[grant_q] = 1'b1;
            state_nxt        = IDLE;
            last_nxt         = grant_q;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      grant_q <= midx_t'(0);
      last_q  <= midx_t'(1);
    end else begin
      state   <= state_nxt;
      grant_q <= grant_nxt;
      last_q  <= last_nxt;
    end
  end

  // Only the granted master's rdata is meaningful; the other sees s_rdata.
  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_rdata
    assign m_rdata[i] = (wd_fire && grant_q == midx_t'(i)) ? TIMEOUT_RDATA : s_rdata;
  end

  assign m0_ready    = m_ready[0];
  assign m1_ready    = m_ready[1];
  assign m0_rdata    = m_rdata[0];
  assign m1_rdata    = m_rdata[1];
  assign timeout_irq = wd_fire;
  assign grant       = grant_q;

endmodule
